// File: rtl/serial_to_parallel_pkg.sv
// Shared definitions for the serial-to-parallel deserializer and the
// downstream parallel load register.
package serial_to_parallel_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } state_t;

endpackage

// File: rtl/serial_to_parallel.sv
// Deserializer: collects qualified serial bits into a WIDTH-bit word with an
// optional trailing even-parity bit, then strobes the word out for one cycle.
module serial_to_parallel
  import serial_to_parallel_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          PARITY_EN = 1'b0,
  localparam int unsigned CNT_W    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             clr,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  output logic             parity_err,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             busy
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sr, sr_d, shifted;
  logic [WIDTH-1:0]   pout_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               pv_d, pe_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_DATA;
      sr         <= '0;
      pout       <= '0;
      pout_valid <= 1'b0;
      parity_err <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      sr         <= sr_d;
      pout       <= pout_d;
      pout_valid <= pv_d;
      parity_err <= pe_d;
      bit_cnt    <= cnt_d;
    end
  end

  // Next-state logic; clr wins over a simultaneous sin_valid
  always_comb begin
    state_d = state_q;
    sr_d    = sr;
    pout_d  = pout;
    cnt_d   = bit_cnt;
    pv_d    = 1'b0;
    pe_d    = 1'b0;
    shifted = MSB_FIRST ? {sr[WIDTH-2:0], sin} : {sin, sr[WIDTH-1:1]};

    if (clr) begin
      cnt_d   = '0;
      state_d = S_DATA;
    end else if (sin_valid) begin
      case (state_q)
        S_DATA: begin
          sr_d = shifted;
          if (bit_cnt == CNT_W'(WIDTH - 1)) begin
            if (PARITY_EN) begin
              cnt_d   = CNT_W'(WIDTH);
              state_d = S_PAR;
            end else begin
              pout_d = shifted;
              pv_d   = 1'b1;
              cnt_d  = '0;
            end
          end else begin
            cnt_d = bit_cnt + CNT_W'(1);
          end
        end
        S_PAR: begin
          pout_d  = sr;
          pv_d    = 1'b1;
          pe_d    = ^{sr, sin};
          cnt_d   = '0;
          state_d = S_DATA;
        end
      endcase
    end
  end

  assign busy = (bit_cnt != '0) || (state_q == S_PAR);

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench: three deserializer configurations (MSB-first,
// LSB-first, MSB-first with parity) compared against a bit-list model.
module tb_serial_to_parallel;

  logic       clk = 1'b0;
  logic [2:0] rst = '0, sin = '0, sin_valid = '0, clr = '0;
  logic [7:0] pout_o [3];
  logic [3:0] cnt_o  [3];
  logic [2:0] pv_o, pe_o, busy_o;

  int total = 0;
  int bad   = 0;

  // Model: received data bits per DUT, count, held word
  bit       mbits [3][8];
  int       mcnt  [3];
  bit [7:0] mpout [3];

  always #5 clk = ~clk;

  serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_msb (
    .clk(clk), .rst(rst[0]), .sin(sin[0]), .sin_valid(sin_valid[0]), .clr(clr[0]),
    .pout(pout_o[0]), .pout_valid(pv_o[0]), .parity_err(pe_o[0]),
    .bit_cnt(cnt_o[0]), .busy(busy_o[0]));

  serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) u_lsb (
    .clk(clk), .rst(rst[1]), .sin(sin[1]), .sin_valid(sin_valid[1]), .clr(clr[1]),
    .pout(pout_o[1]), .pout_valid(pv_o[1]), .parity_err(pe_o[1]),
    .bit_cnt(cnt_o[1]), .busy(busy_o[1]));

  serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_par (
    .clk(clk), .rst(rst[2]), .sin(sin[2]), .sin_valid(sin_valid[2]), .clr(clr[2]),
    .pout(pout_o[2]), .pout_valid(pv_o[2]), .parity_err(pe_o[2]),
    .bit_cnt(cnt_o[2]), .busy(busy_o[2]));

  function automatic bit [7:0] assemble(input int d);
    bit [7:0] w = '0;
    for (int i = 0; i < 8; i++) begin
      if (d == 1) w[i] = mbits[d][i];
      else        w[7-i] = mbits[d][i];
    end
    return w;
  endfunction

  // One clock on DUT d, then model update and full output comparison
  task automatic step(input int d, input bit b, input bit v, input bit c, input bit r);
    bit exp_pv = 1'b0;
    bit exp_pe = 1'b0;
    sin[d] = b; sin_valid[d] = v; clr[d] = c; rst[d] = r;
    @(posedge clk); #1;
    sin_valid[d] = 1'b0; clr[d] = 1'b0; rst[d] = 1'b0;
    if (r) begin
      mcnt[d] = 0; mpout[d] = '0;
    end else if (c) begin
      mcnt[d] = 0;
    end else if (v) begin
      if (mcnt[d] < 8) begin
        mbits[d][mcnt[d]] = b;
        mcnt[d]++;
        if (mcnt[d] == 8 && d != 2) begin
          mpout[d] = assemble(d); exp_pv = 1'b1; mcnt[d] = 0;
        end
      end else begin
        mpout[d] = assemble(d); exp_pv = 1'b1; mcnt[d] = 0;
        exp_pe = 1'(($countones(mpout[d]) + int'(b)) % 2);
      end
    end
    total += 5;
    if (pout_o[d] !== mpout[d]) begin
      bad++; $display("FAIL pout dut%0d: got %h want %h", d, pout_o[d], mpout[d]);
    end
    if (pv_o[d] !== exp_pv) begin
      bad++; $display("FAIL pout_valid dut%0d: got %b want %b", d, pv_o[d], exp_pv);
    end
    if (pe_o[d] !== exp_pe) begin
      bad++; $display("FAIL parity_err dut%0d: got %b want %b", d, pe_o[d], exp_pe);
    end
    if (cnt_o[d] !== 4'(mcnt[d])) begin
      bad++; $display("FAIL bit_cnt dut%0d: got %0d want %0d", d, cnt_o[d], mcnt[d]);
    end
    if (busy_o[d] !== (mcnt[d] != 0)) begin
      bad++; $display("FAIL busy dut%0d: got %b want %b", d, busy_o[d], mcnt[d] != 0);
    end
  endtask

  // Sends n bits of a word in wire order (MSB first unless lsb)
  task automatic send_bits(input int d, input bit [7:0] w, input bit lsb, input int first, input int n);
    for (int i = first; i < first + n; i++)
      step(d, lsb ? w[i] : w[7-i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 3'b111;
    repeat (2) @(posedge clk);
    #1 rst = '0;
    for (int d = 0; d < 3; d++) begin
      mcnt[d] = 0; mpout[d] = '0;
      total += 4;
      if (pout_o[d] !== 8'h00) begin bad++; $display("FAIL reset_pout dut%0d: got %h want 00", d, pout_o[d]); end
      if (pv_o[d] !== 1'b0)    begin bad++; $display("FAIL reset_pv dut%0d: got %b want 0", d, pv_o[d]); end
      if (cnt_o[d] !== 4'd0)   begin bad++; $display("FAIL reset_cnt dut%0d: got %0d want 0", d, cnt_o[d]); end
      if (busy_o[d] !== 1'b0)  begin bad++; $display("FAIL reset_busy dut%0d: got %b want 0", d, busy_o[d]); end
    end
  endtask

  task automatic test_msb_basic();
    send_bits(0, 8'hAA, 1'b0, 0, 8);
    total += 2;
    if (pout_o[0] !== 8'hAA) begin bad++; $display("FAIL msb_word: got %h want aa", pout_o[0]); end
    if (pv_o[0] !== 1'b1)    begin bad++; $display("FAIL msb_strobe: got %b want 1", pv_o[0]); end
    step(0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (pv_o[0] !== 1'b0) begin bad++; $display("FAIL msb_strobe_len: got %b want 0", pv_o[0]); end
  endtask

  task automatic test_lsb();
    send_bits(1, 8'h03, 1'b1, 0, 8);
    total++;
    if (pout_o[1] !== 8'h03) begin bad++; $display("FAIL lsb_word: got %h want 03", pout_o[1]); end
  endtask

  task automatic test_gaps_back_to_back();
    send_bits(0, 8'hF0, 1'b0, 0, 4);
    for (int i = 0; i < 3; i++) begin
      step(0, 1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if (busy_o[0] !== 1'b1) begin bad++; $display("FAIL gap_busy: got %b want 1", busy_o[0]); end
    end
    send_bits(0, 8'hF0, 1'b0, 4, 4);
    total++;
    if (pout_o[0] !== 8'hF0) begin bad++; $display("FAIL gap_word: got %h want f0", pout_o[0]); end
    for (int i = 0; i < 7; i++) begin
      send_bits(0, 8'h0F, 1'b0, i, 1);
      total++;
      if (pout_o[0] !== 8'hF0) begin bad++; $display("FAIL b2b_hold: got %h want f0", pout_o[0]); end
    end
    send_bits(0, 8'h0F, 1'b0, 7, 1);
    total++;
    if (pout_o[0] !== 8'h0F || pv_o[0] !== 1'b1) begin
      bad++; $display("FAIL b2b_word: got %h/%b want 0f/1", pout_o[0], pv_o[0]);
    end
  endtask

  task automatic test_parity();
    for (int p = 0; p < 2; p++) begin
      send_bits(2, 8'hA5, 1'b0, 0, 8);
      total++;
      if (pv_o[2] !== 1'b0 || cnt_o[2] !== 4'd8) begin
        bad++; $display("FAIL par_wait: got pv=%b cnt=%0d want pv=0 cnt=8", pv_o[2], cnt_o[2]);
      end
      step(2, 1'b0, 1'b0, 1'b0, 1'b0);
      step(2, 1'(p), 1'b1, 1'b0, 1'b0);
      total++;
      if (pout_o[2] !== 8'hA5 || pv_o[2] !== 1'b1 || pe_o[2] !== 1'(p)) begin
        bad++; $display("FAIL par_word: got %h/%b/%b want a5/1/%0d", pout_o[2], pv_o[2], pe_o[2], p);
      end
      step(2, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_clr();
    bit [7:0] old;
    old = pout_o[0];
    send_bits(0, 8'h55, 1'b0, 0, 5);
    step(0, 1'b1, 1'b1, 1'b1, 1'b0);
    total++;
    if (cnt_o[0] !== 4'd0 || busy_o[0] !== 1'b0 || pv_o[0] !== 1'b0 || pout_o[0] !== old) begin
      bad++; $display("FAIL clr: got cnt=%0d busy=%b pv=%b pout=%h want 0/0/0/%h",
                      cnt_o[0], busy_o[0], pv_o[0], pout_o[0], old);
    end
    send_bits(0, 8'h3C, 1'b0, 0, 8);
    total++;
    if (pout_o[0] !== 8'h3C) begin bad++; $display("FAIL clr_next: got %h want 3c", pout_o[0]); end
  endtask

  task automatic test_reset_mid();
    send_bits(0, 8'hC3, 1'b0, 0, 7);
    step(0, 1'b1, 1'b1, 1'b0, 1'b1);
    total++;
    if (pv_o[0] !== 1'b0 || pout_o[0] !== 8'h00 || cnt_o[0] !== 4'd0) begin
      bad++; $display("FAIL rst_mid: got pv=%b pout=%h cnt=%0d want 0/00/0", pv_o[0], pout_o[0], cnt_o[0]);
    end
    send_bits(0, 8'h96, 1'b0, 0, 8);
    total++;
    if (pout_o[0] !== 8'h96) begin bad++; $display("FAIL rst_next: got %h want 96", pout_o[0]); end
  endtask

  task automatic test_random();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 300; i++)
        step(d, 1'($urandom), $urandom_range(0, 3) != 0,
             $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0);
  endtask

  initial begin
    test_reset();
    test_msb_basic();
    test_lsb();
    test_gaps_back_to_back();
    test_parity();
    test_clr();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
